// File: rtl/sync_fifo_pkg.sv
// -----------------------------------------------------------------------------
// sync_fifo_pkg
// Shared definitions for the parametrised synchronous FIFO:
//   DEF_WIDTH / DEF_DEPTH : default data width and depth
//   ptr_w(depth)          : pointer width, address bits plus one wrap bit
//   fifo_status_t         : bundle of the four occupancy status flags
// -----------------------------------------------------------------------------
package sync_fifo_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_DEPTH = 1024;

  // Address bits plus one wrap bit, so that full and empty can be told apart.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
  } fifo_status_t;

endpackage

// File: rtl/fifo_ram_2p.sv
// -----------------------------------------------------------------------------
// fifo_ram_2p
// DEPTH x WIDTH storage with one synchronous write port and one synchronous
// read port. There is no reset, so the array can map onto block RAM.
// Ports:
//   clk   : clock, rising edge
//   we    : write enable; waddr / wdata give the write address and data
//   re    : read enable; rdata is loaded from mem[raddr] on the edge
//   rdata : registered read data, held while re is low
// -----------------------------------------------------------------------------
module fifo_ram_2p
  import sync_fifo_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rdata_reg;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata_reg <= mem[raddr];
    end
  end

  assign rdata = rdata_reg;

endmodule

// File: rtl/sync_fifo_param.sv
// -----------------------------------------------------------------------------
// sync_fifo_param
// Single-clock FIFO with power-of-two depth, programmable almost-full /
// almost-empty thresholds, an occupancy count and a registered read-valid
// strobe. Optional sticky overflow/underflow flags are compiled in when the
// macro SYNC_FIFO_ERR_FLAGS_EN is defined.
// Ports:
//   clk          : clock, rising edge
//   rst          : synchronous reset, active low
//   w_en/data_in : write request and data (ignored while full)
//   r_en         : read request (ignored while empty)
//   data_out     : registered read data, holds between accepted reads
//   r_valid      : data_out was loaded by the read accepted on the last edge
//   full/empty/almost_full/almost_empty : status from registered state
//   count        : occupancy, 0..DEPTH
//   clr_err      : (SYNC_FIFO_ERR_FLAGS_EN) clears the sticky error flags
//   overflow     : (SYNC_FIFO_ERR_FLAGS_EN) w_en seen while full
//   underflow    : (SYNC_FIFO_ERR_FLAGS_EN) r_en seen while empty
// -----------------------------------------------------------------------------
module sync_fifo_param
  import sync_fifo_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int AF_THRESH = DEPTH - 4,
  parameter int AE_THRESH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   w_en,
  input  logic [WIDTH-1:0]       data_in,
  input  logic                   r_en,
  output logic [WIDTH-1:0]       data_out,
  output logic                   r_valid,
  output logic                   full,
  output logic                   empty,
  output logic                   almost_full,
  output logic                   almost_empty,
  output logic [$clog2(DEPTH):0] count
`ifdef SYNC_FIFO_ERR_FLAGS_EN
  ,
  input  logic                   clr_err,
  output logic                   overflow,
  output logic                   underflow
`endif
);

  localparam int PW = ptr_w(DEPTH);
  localparam int AW = PW - 1;
  localparam logic [PW-1:0] AF_LVL = PW'(AF_THRESH);
  localparam logic [PW-1:0] AE_LVL = PW'(AE_THRESH);

  logic [PW-1:0]    wr_ptr_reg, wr_ptr_next;
  logic [PW-1:0]    rd_ptr_reg, rd_ptr_next;
  logic [PW-1:0]    count_reg, count_next;
  logic             r_valid_reg;
  // The RAM read register cannot be reset, so data_out is forced to zero
  // from reset until the first accepted read reloads it.
  logic             dout_zero_reg;
  logic [WIDTH-1:0] ram_rdata;
  logic             wr_acc, rd_acc;
  fifo_status_t     status;

  // Full/empty come from the pointers; the thresholds from the count register.
  always_comb begin
    status.empty        = (wr_ptr_reg == rd_ptr_reg);
    status.full         = (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]) &&
                          (wr_ptr_reg[AW] != rd_ptr_reg[AW]);
    status.almost_full  = (count_reg >= AF_LVL);
    status.almost_empty = (count_reg <= AE_LVL);
  end

  assign wr_acc = w_en && !status.full;
  assign rd_acc = r_en && !status.empty;

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (wr_acc) begin
      wr_ptr_next = wr_ptr_reg + PW'(1);
    end
    if (rd_acc) begin
      rd_ptr_next = rd_ptr_reg + PW'(1);
    end
    case ({wr_acc, rd_acc})
      2'b10:   count_next = count_reg + PW'(1);
      2'b01:   count_next = count_reg - PW'(1);
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      r_valid_reg   <= 1'b0;
      dout_zero_reg <= 1'b1;
    end else begin
      wr_ptr_reg  <= wr_ptr_next;
      rd_ptr_reg  <= rd_ptr_next;
      count_reg   <= count_next;
      r_valid_reg <= rd_acc;
      if (rd_acc) begin
        dout_zero_reg <= 1'b0;
      end
    end
  end

  // Write and read addresses can only coincide when full or empty, and in
  // both of those cases one of the two ports is gated off, so no
  // read-during-write collision can occur.
  fifo_ram_2p #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (wr_acc && rst),
    .waddr (wr_ptr_reg[AW-1:0]),
    .wdata (data_in),
    .re    (rd_acc && rst),
    .raddr (rd_ptr_reg[AW-1:0]),
    .rdata (ram_rdata)
  );

  assign data_out     = dout_zero_reg ? '0 : ram_rdata;
  assign r_valid      = r_valid_reg;
  assign full         = status.full;
  assign empty        = status.empty;
  assign almost_full  = status.almost_full;
  assign almost_empty = status.almost_empty;
  assign count        = count_reg;

`ifdef SYNC_FIFO_ERR_FLAGS_EN
  logic overflow_reg, overflow_next;
  logic underflow_reg, underflow_next;

  // A new error in the same cycle as clr_err takes priority over the clear.
  always_comb begin
    overflow_next  = overflow_reg;
    underflow_next = underflow_reg;
    if (w_en && status.full) begin
      overflow_next = 1'b1;
    end else if (clr_err) begin
      overflow_next = 1'b0;
    end
    if (r_en && status.empty) begin
      underflow_next = 1'b1;
    end else if (clr_err) begin
      underflow_next = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      overflow_reg  <= overflow_next;
      underflow_reg <= underflow_next;
    end
  end

  assign overflow  = overflow_reg;
  assign underflow = underflow_reg;
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// -----------------------------------------------------------------------------
// tb_sync_fifo_param
// Self-checking bench for sync_fifo_param (DEPTH=8, WIDTH=32, AF=4, AE=2).
// A queue-based model tracks contents, the last read word, r_valid and the
// error flags; a negedge process compares every output against it, and the
// directed scenarios add literal expectations. Ends with randomized traffic.
// -----------------------------------------------------------------------------
module tb_sync_fifo_param;

  localparam int W  = 32;
  localparam int D  = 8;
  localparam int AF = 4;
  localparam int AE = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         w_en;
  logic [W-1:0] data_in;
  logic         r_en;
  logic [W-1:0] data_out;
  logic         r_valid;
  logic         full;
  logic         empty;
  logic         almost_full;
  logic         almost_empty;
  logic [3:0]   count;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
  logic         clr_err;
  logic         overflow;
  logic         underflow;
`endif

  sync_fifo_param #(
    .WIDTH     (W),
    .DEPTH     (D),
    .AF_THRESH (AF),
    .AE_THRESH (AE)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .w_en         (w_en),
    .data_in      (data_in),
    .r_en         (r_en),
    .data_out     (data_out),
    .r_valid      (r_valid),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count)
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    ,
    .clr_err      (clr_err),
    .overflow     (overflow),
    .underflow    (underflow)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit check_en = 1'b0;

  // Behavioural model
  logic [W-1:0] q[$];
  logic [W-1:0] m_data  = '0;
  bit           m_valid = 1'b0;
  bit           m_ovf   = 1'b0;
  bit           m_udf   = 1'b0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Apply one transaction to the model using the state before the edge.
  task automatic model_step(input bit rs, input bit w, input logic [W-1:0] d,
                            input bit r, input bit c);
    int sz;
    bit w_ok, r_ok;
    sz = q.size();
    if (!rs) begin
      q.delete();
      m_data  = '0;
      m_valid = 1'b0;
      m_ovf   = 1'b0;
      m_udf   = 1'b0;
    end else begin
      w_ok = w && (sz < D);
      r_ok = r && (sz > 0);
      if (w && sz == D) m_ovf = 1'b1;
      else if (c)       m_ovf = 1'b0;
      if (r && sz == 0) m_udf = 1'b1;
      else if (c)       m_udf = 1'b0;
      if (r_ok) m_data = q.pop_front();
      m_valid = r_ok;
      if (w_ok) q.push_back(d);
    end
  endtask

  // One clock cycle: drive inputs, let the edge happen, update the model,
  // then return 1 time unit after the edge.
  task automatic drive(input bit w, input logic [W-1:0] d, input bit r,
                       input bit rs, input bit c);
    rst     = rs;
    w_en    = w;
    data_in = d;
    r_en    = r;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    clr_err = c;
`endif
    @(posedge clk);
    model_step(rs, w, d, r, c);
    #1;
    $display("txn rst=%0b w=%0b d=0x%0h r=%0b clr=%0b -> count=%0d dout=0x%0h rv=%0b",
             rs, w, d, r, c, count, data_out, r_valid);
  endtask

  // Compare process: every output against the model on every cycle.
  always @(negedge clk) begin
    if (check_en) begin
      chk("count", W'(count), W'(q.size()));
      chk("full", W'(full), W'(q.size() == D));
      chk("empty", W'(empty), W'(q.size() == 0));
      chk("almost_full", W'(almost_full), W'(q.size() >= AF));
      chk("almost_empty", W'(almost_empty), W'(q.size() <= AE));
      chk("data_out", data_out, m_data);
      chk("r_valid", W'(r_valid), W'(m_valid));
`ifdef SYNC_FIFO_ERR_FLAGS_EN
      chk("overflow", W'(overflow), W'(m_ovf));
      chk("underflow", W'(underflow), W'(m_udf));
`endif
    end
  end

  initial begin
    int wp;
    int rp;
    rst = 1'b0; w_en = 1'b0; r_en = 1'b0; data_in = '0;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    clr_err = 1'b0;
`endif
    drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    check_en = 1'b1;

    // Reset state
    chk("rst_count", W'(count), 0);
    chk("rst_empty", W'(empty), 1);
    chk("rst_full", W'(full), 0);
    chk("rst_ae", W'(almost_empty), 1);
    chk("rst_af", W'(almost_full), 0);
    chk("rst_dout", data_out, 0);
    chk("rst_rvalid", W'(r_valid), 0);

    // Fill 1..8, drain in order
    for (int i = 1; i <= 8; i++) begin
      drive(1, W'(i), 0, 1, 0);
      if (i == 3) chk("af_at3", W'(almost_full), 0);
      if (i == 4) chk("af_at4", W'(almost_full), 1);
      if (i == 7) chk("full_at7", W'(full), 0);
    end
    chk("fill_count", W'(count), 8);
    chk("fill_full", W'(full), 1);
    for (int i = 1; i <= 8; i++) begin
      drive(0, 0, 1, 1, 0);
      chk("drain_data", data_out, W'(i));
      chk("drain_rvalid", W'(r_valid), 1);
    end
    drive(0, 0, 0, 1, 0);
    chk("drain_rvalid_off", W'(r_valid), 0);
    chk("drain_empty", W'(empty), 1);

    // Overflow: 12 writes, only the first 8 stored
    for (int i = 1; i <= 12; i++) drive(1, 32'h100 + W'(i), 0, 1, 0);
    chk("ovf_count", W'(count), 8);
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    chk("ovf_flag", W'(overflow), 1);
`endif
    for (int i = 1; i <= 8; i++) begin
      drive(0, 0, 1, 1, 0);
      chk("ovf_data", data_out, 32'h100 + W'(i));
    end
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    chk("ovf_sticky", W'(overflow), 1);
    drive(0, 0, 0, 1, 1);
    chk("ovf_clr", W'(overflow), 0);
`endif

    // Simultaneous read+write while full: read only
    for (int i = 1; i <= 8; i++) drive(1, 32'h200 + W'(i), 0, 1, 0);
    drive(1, 32'hDEAD, 1, 1, 0);
    chk("fullrw_count", W'(count), 7);
    chk("fullrw_full", W'(full), 0);
    chk("fullrw_data", data_out, 32'h201);
    for (int i = 2; i <= 8; i++) begin
      drive(0, 0, 1, 1, 0);
      chk("fullrw_drain", data_out, 32'h200 + W'(i));
    end

    // Simultaneous read+write while empty: write only
    drive(1, 32'h300, 1, 1, 0);
    chk("emptyrw_count", W'(count), 1);
    chk("emptyrw_rvalid", W'(r_valid), 0);
    chk("emptyrw_hold", data_out, 32'h208);
    drive(0, 0, 1, 1, 0);
    chk("emptyrw_data", data_out, 32'h300);

    // Steady state at count 4 with read+write every cycle (pointer wrap)
    for (int i = 0; i < 4; i++) drive(1, 32'h400 + W'(i), 0, 1, 0);
    for (int k = 0; k < 20; k++) begin
      drive(1, 32'h404 + W'(k), 1, 1, 0);
      chk("stream_data", data_out, 32'h400 + W'(k));
      chk("stream_count", W'(count), 4);
    end
    for (int i = 0; i < 4; i++) drive(0, 0, 1, 1, 0);
    chk("stream_last", data_out, 32'h417);

    // Reset mid-traffic with w_en and r_en asserted
    for (int i = 0; i < 5; i++) drive(1, 32'h500 + W'(i), 0, 1, 0);
    drive(0, 0, 1, 1, 0);
    drive(0, 0, 1, 1, 0);
    drive(1, 32'h5FF, 1, 0, 0);
    chk("mrst_count", W'(count), 0);
    chk("mrst_empty", W'(empty), 1);
    chk("mrst_dout", data_out, 0);
    chk("mrst_rvalid", W'(r_valid), 0);
    drive(1, 32'h600, 0, 1, 0);
    drive(0, 0, 1, 1, 0);
    chk("mrst_newword", data_out, 32'h600);

    // Read on empty after reset
    drive(0, 0, 0, 0, 0);
    drive(0, 0, 1, 1, 0);
    chk("udf_dout", data_out, 0);
    chk("udf_rvalid", W'(r_valid), 0);
    chk("udf_count", W'(count), 0);
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    chk("udf_flag", W'(underflow), 1);
    drive(0, 0, 1, 1, 1);
    chk("udf_set_wins", W'(underflow), 1);
    drive(0, 0, 0, 1, 1);
    chk("udf_clr", W'(underflow), 0);
`endif

    // Randomized traffic in phases of varying write/read bias
    for (int ph = 0; ph < 15; ph++) begin
      wp = $urandom_range(10, 90);
      rp = $urandom_range(10, 90);
      for (int k = 0; k < 100; k++) begin
        drive($urandom_range(0, 99) < wp, $urandom, $urandom_range(0, 99) < rp,
              $urandom_range(0, 199) != 0, $urandom_range(0, 19) == 0);
      end
    end

    drive(0, 0, 0, 1, 0);
    check_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sync_fifo_param.md
# sync_fifo_param

Parametrised single-clock FIFO: configurable data width, power-of-two depth and programmable almost-full/almost-empty thresholds, plus an occupancy count and a registered read-valid strobe. It is the general-purpose buffering block for same-clock producer/consumer paths. Overflow/underflow error flags can be compiled in.

## Interface
- WIDTH, 32, data word width in bits (≥1)
- DEPTH, 1024, number of entries; power of two, ≥2
- AF_THRESH, DEPTH-4, almost_full asserts when count ≥ AF_THRESH
- AE_THRESH, 4, almost_empty asserts when count ≤ AE_THRESH
- clk  input  1  clock, all logic on rising edge
- rst  input  1  reset, synchronous, active-low
- w_en  input  1  write request
- data_in  input  WIDTH  write data
- r_en  input  1  read request
- data_out  output  WIDTH  registered read data
- r_valid  output  1  data_out updated by an accepted read this cycle
- full  output  1  count == DEPTH
- empty  output  1  count == 0
- almost_full  output  1  count ≥ AF_THRESH
- almost_empty  output  1  count ≤ AE_THRESH
- count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
- overflow, underflow, clr_err: see Configuration

## Operation
- Pointers: wr_ptr, rd_ptr, each $clog2(DEPTH)+1 bits; low bits address, MSB is wrap bit. empty = pointers equal; full = addresses equal, wrap bits differ. Both roll over naturally from 2·DEPTH−1 to 0.
- Write accepted iff w_en && !full: mem[wr_ptr addr] ← data_in, wr_ptr+1.
- Read accepted iff r_en && !empty: data_out ← mem[rd_ptr addr], rd_ptr+1, r_valid=1 on next cycle.
- Rejected requests are ignored. Pointers, memory and data_out are unchanged.
- Full and empty are evaluated on pre-edge state. When full, a simultaneous w_en+r_en performs the read only. When empty, it performs the write only. Otherwise both are accepted and count is unchanged.
- count: +1 on write-only, −1 on read-only, unchanged otherwise. It is held as a register and never exceeds DEPTH.
- data_out holds its last value when no read is accepted.
- Reset (rst=0 at edge): wr_ptr=rd_ptr=0, count=0, data_out=0, r_valid=0. Outputs become empty=1, full=0, almost_empty=1, almost_full=0 (AF_THRESH>0). Memory contents are not cleared.
- Reset has priority over any w_en/r_en in the same cycle, including mid-burst.

## Timing
- Status flags are combinational from registered pointers/count. They change the cycle after the accepting edge.
- Write-to-read latency: a word written at edge T is readable by r_en sampled at edge T+1. It appears on data_out after edge T+1. There is no write-through bypass.
- Read latency: 1 cycle. r_valid pulses exactly one cycle per accepted read. Back-to-back reads give continuous r_valid.
- Sustained throughput: one write and one read per cycle.

## Configuration
- Macro SYNC_FIFO_ERR_FLAGS_EN.
- Defined: ports overflow, underflow (outputs) and clr_err (input) exist.
  - overflow is set by w_en while full.
  - underflow is set by r_en while empty.
  - Both are sticky and are cleared by clr_err=1 or reset.
  - If clr_err and a new error occur in the same cycle, the set wins.
  - Flags are registered: visible the cycle after the offending edge.
- Undefined: those three ports and their logic are absent. Rejected requests remain silently ignored.

## Structure
- Package sync_fifo_pkg holds:
  - default WIDTH/DEPTH constants
  - ptr_w(depth) function returning $clog2(depth)+1
  - a status struct typedef {full, empty, almost_full, almost_empty}
- Sub-module fifo_ram_2p provides the storage: DEPTH×WIDTH, one synchronous write port and one synchronous read port, no reset.
- Top level contains pointers, count, flag logic and error flags.

## Test plan
- DEPTH=8, WIDTH=32: reset, write 0x1..0x8 → full=1 after 8th edge, count=8, almost_full=1 from count 4 (AF_THRESH=4). Read 8 → data_out 0x1..0x8 in order with r_valid each cycle, then empty=1.
- Write 12 words to empty DEPTH=8 FIFO with no reads → words 9–12 dropped, count=8. Reading returns 0x1..0x8. With macro, overflow=1 and stays 1 until clr_err.
- When full, w_en=r_en=1 for one cycle → only the read is accepted: count 8→7, full=0, the write word is not stored. When empty, both asserted → count 0→1 and r_valid=0.
- Fill to 4, then 20 cycles of simultaneous read+write with incrementing data → count stays 4, output sequence contiguous, pointers wrap twice with no loss.
- Write 5 words, read 2, assert rst=0 with w_en=r_en=1 → next cycle count=0, empty=1, data_out=0, r_valid=0. A subsequent write/read returns the new word.
- r_en on empty after reset → data_out stays 0, r_valid=0, count=0. With macro, underflow=1. clr_err clears it the next cycle.
